// File: rtl/keyboard_inner_driver.sv
// PS/2 keyboard receiver: synchronizes and filters the raw bus, assembles
// 11-bit frames and presents each validated byte until the consumer reads it.
module keyboard_inner_driver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock50,
   input  logic       reset,
   input  logic       keyboard_clk,
   input  logic       keyboard_data,
   input  logic       read,
   output logic       scan_ready,
   output logic [7:0] scan_code
);

   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {
      IDLE,
      RECV
   } state_t;

   state_t                state, state_n;
   logic                  clk_meta, clk_sync;
   logic                  dat_meta, dat_sync;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  filt, filt_d;
   logic                  fall;
   logic [9:0]            frame;
   logic [3:0]            bit_cnt, bit_cnt_n;
   logic [IW-1:0]         idle_cnt, idle_cnt_n;
   logic                  done;
   logic                  valid;

   // Everything on the bus side idles high so reset never fakes an edge.
   always_ff @(posedge clock50) begin
      if (reset) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
         filt_sr  <= '1;
         filt     <= 1'b1;
         filt_d   <= 1'b1;
      end else begin
         clk_meta <= keyboard_clk;
         clk_sync <= clk_meta;
         dat_meta <= keyboard_data;
         dat_sync <= dat_meta;
         filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_sync};
         if (&filt_sr)
            filt <= 1'b1;
         else if (~|filt_sr)
            filt <= 1'b0;
         filt_d   <= filt;
      end
   end

   assign fall = filt_d & ~filt;

   always_ff @(posedge clock50) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         idle_cnt <= '0;
         frame    <= '0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         idle_cnt <= idle_cnt_n;
         if (fall)
            frame <= {dat_sync, frame[9:1]};
      end
   end

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      idle_cnt_n = idle_cnt;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            idle_cnt_n = '0;
            if (fall) begin
               bit_cnt_n = 4'd1;
               state_n   = RECV;
            end
         end
         RECV: begin
            if (fall) begin
               idle_cnt_n = '0;
               if (bit_cnt == 4'd10) begin
                  bit_cnt_n = 4'd0;
                  state_n   = IDLE;
                  done      = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end else if (idle_cnt == IW'(TIMEOUT_CYCLES)) begin
               bit_cnt_n  = 4'd0;
               idle_cnt_n = '0;
               state_n    = IDLE;
            end else begin
               idle_cnt_n = idle_cnt + IW'(1);
            end
         end
         default: begin
            bit_cnt_n  = 4'd0;
            idle_cnt_n = '0;
            state_n    = IDLE;
         end
      endcase
   end

   // frame[0] holds the start bit, frame[9] the parity; the stop bit is live.
   assign valid = done & ~frame[0] & dat_sync & (^frame[9:1]);

   always_ff @(posedge clock50) begin
      if (reset) begin
         scan_ready <= 1'b0;
         scan_code  <= 8'h00;
      end else if (valid) begin
         scan_ready <= 1'b1;
         scan_code  <= frame[8:1];
      end else if (read) begin
         scan_ready <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keyboard_inner_driver.sv
// Directed and randomized PS/2 frames checked against a byte-level
// model of what the consumer should see.
module tb_keyboard_inner_driver;

   localparam int FL   = 8;
   localparam int TO   = 2000;
   localparam int HALF = 40;
   localparam int LAT  = FL + 4;

   logic       clock50 = 1'b0;
   logic       reset   = 1'b1;
   logic       kc      = 1'b1;
   logic       kd      = 1'b1;
   logic       read    = 1'b0;
   logic       scan_ready;
   logic [7:0] scan_code;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_code = 8'h00;
   logic       exp_ready = 1'b0;

   keyboard_inner_driver #(
      .FILTER_LEN    (FL),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock50      (clock50),
      .reset        (reset),
      .keyboard_clk (kc),
      .keyboard_data(kd),
      .read         (read),
      .scan_ready   (scan_ready),
      .scan_code    (scan_code)
   );

   always #10 clock50 = ~clock50;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_code"}, {24'd0, scan_code}, {24'd0, exp_code});
      chk({tag, "_ready"}, {31'd0, scan_ready}, {31'd0, exp_ready});
   endtask

   // err: 0 none, 1 parity, 2 start, 3 stop
   function automatic logic [10:0] mk(input logic [7:0] d, input int err);
      logic [10:0] f;
      f = {1'b1, ~^d, d, 1'b0};
      if (err == 1) f[9] = ~f[9];
      if (err == 2) f[0] = 1'b1;
      if (err == 3) f[10] = 1'b0;
      return f;
   endfunction

   task automatic apply(input logic [7:0] d, input int err);
      if (err == 0) begin
         exp_code  = d;
         exp_ready = 1'b1;
      end
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         kd = f[i];
         repeat (HALF) @(negedge clock50);
         kc = 1'b0;
         repeat (HALF) @(negedge clock50);
         kc = 1'b1;
      end
   endtask

   task automatic last_fall(input logic [10:0] f);
      send_bits(f, 10);
      kd = f[10];
      repeat (HALF) @(negedge clock50);
      kc = 1'b0;
   endtask

   task automatic finish_frame();
      repeat (HALF) @(negedge clock50);
      kc = 1'b1;
      kd = 1'b1;
      repeat (2 * HALF) @(negedge clock50);
   endtask

   task automatic send_frame(input logic [10:0] f);
      last_fall(f);
      finish_frame();
   endtask

   task automatic do_reset(input int n);
      @(negedge clock50);
      reset = 1'b1;
      repeat (n) @(negedge clock50);
      reset = 1'b0;
      exp_code  = 8'h00;
      exp_ready = 1'b0;
   endtask

   task automatic pulse_read(input string tag);
      @(negedge clock50);
      read = 1'b1;
      @(posedge clock50);
      #1;
      read = 1'b0;
      exp_ready = 1'b0;
      check_out(tag);
   endtask

   initial begin
      logic [7:0] d;
      int         err;

      do_reset(3);
      check_out("reset");

      // valid 0x1C with exact completion latency
      last_fall(mk(8'h1C, 0));
      repeat (LAT - 1) @(posedge clock50);
      #1;
      check_out("pre_1c");
      @(posedge clock50);
      #1;
      apply(8'h1C, 0);
      check_out("done_1c");
      finish_frame();

      // parity error then valid 0xF0
      do_reset(2);
      send_frame(mk(8'h1C, 1));
      check_out("bad_par");
      send_frame(mk(8'hF0, 0));
      apply(8'hF0, 0);
      check_out("f0");

      // read clears, then read on the completion edge loses to the set
      do_reset(2);
      send_frame(mk(8'h1C, 0));
      apply(8'h1C, 0);
      check_out("pre_read");
      pulse_read("read_clr");
      last_fall(mk(8'h32, 0));
      repeat (LAT - 1) @(posedge clock50);
      #1;
      check_out("pre_32");
      read = 1'b1;
      @(posedge clock50);
      #1;
      read = 1'b0;
      apply(8'h32, 0);
      check_out("read_vs_set");
      finish_frame();
      check_out("hold_32");

      // short glitch on an idle line
      pulse_read("clr_glitch");
      kc = 1'b0;
      repeat (3) @(negedge clock50);
      kc = 1'b1;
      repeat (40) @(negedge clock50);
      check_out("glitch");
      send_frame(mk(8'h1C, 0));
      apply(8'h1C, 0);
      check_out("after_glitch");

      // partial frame timeout
      send_bits(mk(8'h77, 0), 4);
      repeat (TO + 1000) @(negedge clock50);
      check_out("timeout_hold");
      send_frame(mk(8'h29, 0));
      apply(8'h29, 0);
      check_out("after_timeout");

      // partial frame cut by reset
      send_bits(mk(8'h77, 0), 4);
      do_reset(1);
      check_out("mid_reset");
      send_frame(mk(8'h5A, 0));
      apply(8'h5A, 0);
      check_out("after_reset");

      // randomized frames, overwrites and reads
      for (int n = 0; n < 14; n++) begin
         d   = 8'($urandom_range(0, 255));
         err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         send_frame(mk(d, err));
         apply(d, err);
         check_out("rand");
         if ($urandom_range(0, 2) == 0)
            pulse_read("rand_read");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keyboard_inner_driver.md
KEYBOARD_INNER_DRIVER -- requirements
Module: keyboard_inner_driver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal clock50 samples needed to change the filtered PS/2 clock level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clock50 cycles mid-frame before the frame is aborted (1 ms at 50 MHz).
REQ-003 SHALL have port clock50, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port keyboard_clk, input, 1 bit: raw, asynchronous PS/2 clock line.
REQ-006 SHALL have port keyboard_data, input, 1 bit: raw, asynchronous PS/2 data line.
REQ-007 SHALL have port read, input, 1 bit: consumer acknowledge; level-sensitive.
REQ-008 SHALL have port scan_ready, output, 1 bit: a new, validated scan_code is pending.
REQ-009 SHALL have port scan_code, output, 8 bits: last validated received byte.

Function
REQ-010 SHALL pass keyboard_clk and keyboard_data each through a 2-flop synchronizer on clock50.
REQ-011 SHALL filter the synchronized clock with a FILTER_LEN-deep shift register:
- filtered level -> 0 only when all samples are 0;
- filtered level -> 1 only when all samples are 1;
- otherwise the filtered level holds.
REQ-012 SHALL detect a falling edge as filtered level 1 in the previous cycle and 0 in the current cycle; it SHALL sample the synchronized data exactly once per falling edge.
REQ-013 SHALL receive 11-bit frames: start (0), data bits D0..D7 LSB first, odd parity, stop (1); a bit counter 0..10 SHALL track the position.
REQ-014 SHALL check the frame when the 11th bit is sampled. Valid = start 0, stop 1, and an odd count of ones over D0..D7 plus parity.
REQ-015 On a valid frame, at that same clock edge:
- scan_code <= D7..D0;
- scan_ready <= 1.
Both SHALL be visible in the cycle after the stop-bit falling edge is detected.
REQ-016 On an invalid frame (start, stop or parity error), scan_code and scan_ready SHALL be unchanged and the frame SHALL be discarded.
REQ-017 After the 11th bit, valid or not, the bit counter SHALL return to 0.
REQ-018 While the bit counter is non-zero, an idle counter SHALL count cycles without a falling edge; it SHALL reset to 0 on each falling edge.
REQ-019 When the idle counter reaches TIMEOUT_CYCLES, the bit counter SHALL return to 0 and the partial frame SHALL be discarded; outputs SHALL be unchanged.
REQ-020 scan_ready SHALL remain 1 until cleared. It SHALL be cleared on the clock edge where read=1 and no valid frame completes.
REQ-021 If a valid frame completes in the same cycle as read=1, scan_ready SHALL be 1 (the set wins) and scan_code SHALL take the new byte.
REQ-022 A valid frame arriving while scan_ready=1 SHALL overwrite scan_code (no queue); scan_ready SHALL stay 1.
REQ-023 read SHALL have no effect on the receive state machine.
REQ-024 Receive states:
- IDLE (count 0): waits for a falling edge.
- RECV (count 1..10): samples bits.
- Completion occurs on the edge that samples count 10.
- Timeout abort returns to IDLE.

Reset
REQ-025 On clock50 rising edge with reset=1:
- scan_ready <= 0; scan_code <= 8'h00;
- bit counter and idle counter <= 0;
- synchronizer flops, filter shift register and filtered level <= 1 (idle-high bus).
REQ-026 Reset SHALL override read and any in-progress frame; a partial frame interrupted by reset SHALL be discarded.

Verification
REQ-027 Valid frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), PS/2 half-period 20 us -> scan_code=8'h1C, scan_ready=1 one cycle after the final falling edge.
REQ-028 Frame 0x1C with parity bit 1 -> scan_ready stays 0, scan_code stays 8'h00; a following valid frame 0xF0 (parity 1) -> scan_code=8'hF0, scan_ready=1.
REQ-029 After a valid 0x1C, a 1-cycle read=1 -> scan_ready=0 next cycle, scan_code still 8'h1C; read=1 held exactly on the completion cycle of frame 0x32 -> scan_ready=1, scan_code=8'h32.
REQ-030 A 3-cycle low glitch on keyboard_clk while the line is idle -> no bit sampled; a subsequent valid 0x1C is received correctly.
REQ-031 Four bits of a frame, then 60000 idle cycles, then a full valid 0x29 frame -> scan_code=8'h29, scan_ready=1; same partial frame interrupted by a 1-cycle reset -> outputs 0, and the next valid frame is received correctly.
